// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch initiator. Owns the PC (a word index) and the
// BOOT/RUN/HALT fetch state machine. It presents the PC to inst_mem and
// latches the returned word into the IF/ID pipeline register. It also applies
// stall and branch/jump redirects that come from downstream stages.
//
// Optional feature macro: FETCH_FLUSH_EN
//   defined   : a redirect in RUN squashes the wrong-path word. IF/ID gets
//               NOP_WORD with valid=0, whatever the value of stall.
//   undefined : delay-slot behaviour. A redirect in RUN still issues the
//               current word, or holds IF/ID if stall=1. A redirect on the
//               HALT_PC word issues that word but does not enter HALT.
//
// Ports
//   clk          in   1  : single clock
//   rst          in   1  : synchronous active-high reset
//   stall        in   1  : hold the PC and IF/ID (ignored in BOOT and HALT)
//   redirect     in   1  : branch/jump taken (ignored in BOOT)
//   redirect_pc  in  32  : word-index redirect target
//   inst_addr    out 32  : word address to inst_mem, driven straight from the PC flop
//   inst_data    in  32  : combinational read data from inst_mem
//   ifid_instr   out 32  : latched instruction
//   ifid_npc     out 32  : latched PC+1
//   ifid_valid   out  1  : the IF/ID entry is a real instruction
//   halted       out  1  : fetch state is HALT
//   fetch_count  out 32  : number of instructions issued (saturating)
//   dbg_state    out  2  : current FSM state (0=BOOT, 1=RUN, 2=HALT)
//
// Handshake: no valid/ready pairing. The downstream stage qualifies the IF/ID
// contents with ifid_valid. It throttles fetch with stall and steers it with
// redirect/redirect_pc. Both are sampled on every rising clk edge.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] HALT_PC  = 32'd127,
  parameter logic [31:0] NOP_WORD = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid,
  output logic        halted,
  output logic [31:0] fetch_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_npc;
  logic        r_valid;
  logic        r_halted;
  logic [31:0] r_count;

  logic [31:0] w_pc_inc;
  logic [31:0] w_count_inc;

  // The PC wraps modulo 2^32. The fetch counter sticks at all-ones.
  assign w_pc_inc    = r_pc + 32'd1;
  assign w_count_inc = (r_count == 32'hFFFF_FFFF) ? r_count : (r_count + 32'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_BOOT;
      r_pc     <= RESET_PC;
      r_instr  <= NOP_WORD;
      r_npc    <= 32'd0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_count  <= 32'd0;
    end else begin
      case (r_state)
        // BOOT is a one-cycle settle. The PC is held and redirect is ignored.
        S_BOOT: begin
          r_state <= S_RUN;
        end

        S_RUN: begin
          if (redirect) begin
            r_pc <= redirect_pc;
`ifdef FETCH_FLUSH_EN
            r_instr <= NOP_WORD;
            r_valid <= 1'b0;
`else
            // Delay slot: the current word still issues, unless stalled.
            // No HALT check here, because the redirect overrides it.
            if (!stall) begin
              r_instr <= inst_data;
              r_npc   <= w_pc_inc;
              r_valid <= 1'b1;
              r_count <= w_count_inc;
            end
`endif
          end else if (!stall) begin
            r_instr <= inst_data;
            r_npc   <= w_pc_inc;
            r_valid <= 1'b1;
            r_count <= w_count_inc;
            // Issuing HALT_PC parks the PC on that word.
            if (r_pc == HALT_PC) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_pc <= w_pc_inc;
            end
          end
        end

        // HALT feeds bubbles and waits for a redirect. stall is ignored.
        // ifid_npc keeps its last value.
        S_HALT: begin
          r_instr <= NOP_WORD;
          r_valid <= 1'b0;
          if (redirect) begin
            r_pc     <= redirect_pc;
            r_state  <= S_RUN;
            r_halted <= 1'b0;
          end
        end

        default: begin
          r_state <= S_BOOT;
        end
      endcase
    end
  end

  assign inst_addr   = r_pc;
  assign ifid_instr  = r_instr;
  assign ifid_npc    = r_npc;
  assign ifid_valid  = r_valid;
  assign halted      = r_halted;
  assign fetch_count = r_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Checks fetch_unit against a cycle-level reference model of the fetch rules.
// The model keeps a mode (boot/run/halt), the PC, and the IF/ID contents.
// A driver applies the inputs for one cycle and pushes the expected
// post-edge outputs into exp_q. A monitor on the falling edge pops the queue
// and compares. The run covers directed scenarios first, then random traffic.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'd0;
  localparam logic [31:0] HALT_PC  = 32'd24;
  localparam logic [31:0] NOP_WORD = 32'h8000_0000;
  localparam int          EXP_W    = 130;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_npc;
  logic        ifid_valid;
  logic        halted;
  logic [31:0] fetch_count;
  logic [1:0]  dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [128];
  assign inst_data = mem[inst_addr[6:0]];

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .HALT_PC  (HALT_PC),
    .NOP_WORD (NOP_WORD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_addr   (inst_addr),
    .inst_data   (inst_data),
    .ifid_instr  (ifid_instr),
    .ifid_npc    (ifid_npc),
    .ifid_valid  (ifid_valid),
    .halted      (halted),
    .fetch_count (fetch_count),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EXP_W-1:0] e;
      e = exp_q.pop_front();
      chk("inst_addr",   inst_addr,            e[129:98]);
      chk("ifid_instr",  ifid_instr,           e[97:66]);
      chk("ifid_npc",    ifid_npc,             e[65:34]);
      chk("ifid_valid",  {31'd0, ifid_valid},  {31'd0, e[33]});
      chk("halted",      {31'd0, halted},      {31'd0, e[32]});
      chk("fetch_count", fetch_count,          e[31:0]);
    end
  end

  // ---------------- reference model ----------------
  // mode: 0 = boot (one idle cycle), 1 = running, 2 = halted
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_npc, m_cnt;
  logic        m_valid;

  task automatic model_step(input bit r, input bit st, input bit rd, input logic [31:0] rpc);
    bit issue;
    if (r) begin
      m_mode = 0; m_pc = RESET_PC; m_instr = NOP_WORD; m_npc = 0; m_valid = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      issue = !st;
`ifdef FETCH_FLUSH_EN
      if (rd) begin
        issue = 0;
        m_instr = NOP_WORD;
        m_valid = 0;
      end
`endif
      if (issue) begin
        m_instr = mem[m_pc[6:0]];
        m_npc   = m_pc + 1;
        m_valid = 1;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
      if (rd) m_pc = rpc;
      else if (issue) begin
        if (m_pc == HALT_PC) m_mode = 2;
        else m_pc = m_pc + 1;
      end
    end else begin
      m_instr = NOP_WORD;
      m_valid = 0;
      if (rd) begin
        m_pc = rpc;
        m_mode = 1;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit st, input bit rd, input logic [31:0] rpc);
    rst = r; stall = st; redirect = rd; redirect_pc = rpc;
    model_step(r, st, rd, rpc);
    exp_q.push_back({m_pc, m_instr, m_npc, m_valid, (m_mode == 2), m_cnt});
    @(posedge clk);
    #1;
  endtask

  // Free-run until the model sits in RUN at the given PC, within a cycle budget.
  task automatic run_until(input logic [31:0] pc, input int budget);
    int n;
    n = 0;
    while (!(m_mode == 1 && m_pc == pc) && n < budget) begin
      step(0, 0, 0, 0);
      n++;
    end
    total++;
    if (!(m_mode == 1 && m_pc == pc)) begin
      bad++;
      $display("FAIL run_until: model pc %0d not reached, at %0d", pc, m_pc);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int wait_n;
    bit st, rd, r;
    logic [31:0] rpc;
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    #1;

    // Reset, then free run: inst_addr 0,0,1,2,3 ...
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0);

    // Stall at PC=4 for three cycles, then release.
    run_until(32'd4, 10);
    repeat (3) step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // Redirect at PC=6 to 20.
    run_until(32'd6, 10);
    step(0, 0, 1, 32'd20);
    step(0, 0, 0, 0);

    // Free run into HALT at 24; stall and redirect both ignored except redirect.
    run_until(32'd24, 10);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 32'd0);
    repeat (2) step(0, 0, 0, 0);

    // Redirect and stall together at PC=8: redirect wins.
    run_until(32'd8, 20);
    step(0, 1, 1, 32'd2);
    step(0, 0, 0, 0);

    // Reset during a stall at PC=10.
    run_until(32'd10, 20);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Redirect on the HALT_PC word itself.
    run_until(32'd24, 40);
    step(0, 0, 1, 32'd5);
    repeat (2) step(0, 0, 0, 0);

    // Redirect during BOOT is ignored.
    step(1, 0, 0, 0);
    step(0, 0, 1, 32'd50);
    repeat (2) step(0, 0, 0, 0);

    // Random traffic, including wrap-around targets.
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 99) < 2);
      st = ($urandom_range(0, 99) < 25);
      rd = ($urandom_range(0, 99) < 12);
      if ($urandom_range(0, 3) == 0) rpc = $urandom;
      else rpc = $urandom_range(0, 30);
      step(r, st, rd, rpc);
    end
    step(0, 0, 0, 0);

    // Drain the scoreboard with a bounded wait.
    wait_n = 0;
    while (exp_q.size() > 0 && wait_n < 10) begin
      @(posedge clk);
      wait_n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
